// File: rtl/toy_pack.sv
// Shared constants and types for the toy_commit_ctrl slice.
// Holds the debug vectors, the xRET type encoding and the front-end lock states.
package toy_pack;

  localparam logic [31:0] DBG_PC_ADDR   = 32'h0000_0800;
  localparam logic [31:0] DBG_LOOP_ADDR = 32'h0000_0808;
  localparam logic [31:0] DBG_EXP_ADDR  = 32'h0000_080C;

  typedef enum logic [1:0] {
    RET_SRET = 2'b00,
    RET_MRET = 2'b01,
    RET_DRET = 2'b10,
    RET_RSVD = 2'b11
  } ret_type_e;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'b00,
    LOCK_ENTER    = 2'b01,
    LOCK_EXIT     = 2'b10
  } lock_state_e;

endpackage

// File: rtl/toy_commit_lane_sel.sv
// Youngest-lane pick, instruction length and retire popcount for the commit window.
// Honours retire_rvc only when TOY_COMMIT_RVC_EN is defined.
module toy_commit_lane_sel #(
  parameter int RETIRE_PORTS = 4,
  parameter int IDX_W        = (RETIRE_PORTS > 1) ? $clog2(RETIRE_PORTS) : 1,
  parameter int CNT_W        = $clog2(RETIRE_PORTS + 1)
) (
  input  logic [RETIRE_PORTS-1:0] retire_vld,
  input  logic [RETIRE_PORTS-1:0] retire_rvc,
  output logic [IDX_W-1:0]        young_idx,
  output logic [2:0]              young_ilen,
  output logic [CNT_W-1:0]        retire_cnt
);

  // Scan lanes oldest to youngest; the last valid lane wins.
  always_comb begin
    young_idx  = {IDX_W{1'b0}};
    retire_cnt = {CNT_W{1'b0}};
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      if (retire_vld[i]) begin
        young_idx  = IDX_W'(i);
        retire_cnt = retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retire_cnt = retire_cnt;
      end
    end
  end

`ifdef TOY_COMMIT_RVC_EN
  assign young_ilen = retire_rvc[young_idx] ? 3'd2 : 3'd4;
`else
  logic unused_rvc_s;
  assign unused_rvc_s = ^retire_rvc;
  assign young_ilen   = 3'd4;
`endif

endmodule

// File: rtl/toy_commit_ctrl.sv
// Commit/redirect controller: architectural PC, redirect arbitration, lock FSM, instret.
// Build macro TOY_COMMIT_RVC_EN enables 16-bit PC advance; TOY_SIM enables input checks.
module toy_commit_ctrl
  import toy_pack::*;
#(
  parameter int                    RETIRE_PORTS = 4,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [RETIRE_PORTS-1:0]                retire_vld,
  input  logic [RETIRE_PORTS-1:0][ADDR_WIDTH-1:0] retire_pc,
  input  logic [RETIRE_PORTS-1:0]                retire_rvc,
  input  logic [RETIRE_PORTS-1:0]                retire_jb,
  input  logic                                   jb_pc_release_en,
  input  logic                                   jb_pc_update_en,
  input  logic [ADDR_WIDTH-1:0]                  jb_pc_val,
  input  logic                                   trap_vld,
  input  logic                                   debug_vld,
  input  logic                                   trap_rdy,
  input  logic                                   indebug_break_en,
  input  logic                                   indebug_exception,
  input  logic                                   debug_step_en,
  input  logic [ADDR_WIDTH-1:0]                  csr_mtvec,
  input  logic [ADDR_WIDTH-1:0]                  csr_mepc,
  input  logic [ADDR_WIDTH-1:0]                  csr_sepc,
  input  logic [ADDR_WIDTH-1:0]                  csr_dpc,
  input  logic                                   spu_return_en,
  input  logic [1:0]                             spu_return_type,
  input  logic                                   instret_inhibit,
  output logic [ADDR_WIDTH-1:0]                  real_pc,
  output logic                                   pc_release_en,
  output logic                                   pc_update_en,
  output logic [ADDR_WIDTH-1:0]                  pc_val,
  output logic                                   pc_lock,
  output logic                                   mret_en,
  output logic                                   sret_en,
  output logic                                   dret_en,
  output logic [63:0]                            instret_cnt
);

  localparam int IDX_W = (RETIRE_PORTS > 1) ? $clog2(RETIRE_PORTS) : 1;
  localparam int CNT_W = $clog2(RETIRE_PORTS + 1);

  logic [IDX_W-1:0]      young_idx_s;
  logic [2:0]            young_ilen_s;
  logic [CNT_W-1:0]      retire_cnt_s;
  logic                  commit_en_s, jb_ret_s, trap_hs_s, debug_hs_s, ret_pulse_s;
  logic [ADDR_WIDTH-1:0] next_pc_s, trap_tgt_s, ret_tgt_s, cur_pc_nxt_s;
  logic                  rd_rel_s, rd_upd_s;
  logic [ADDR_WIDTH-1:0] rd_val_s;
  lock_state_e           lock_nxt_s;

  logic [ADDR_WIDTH-1:0] current_pc_r, pc_val_r;
  logic                  pc_release_en_r, pc_update_en_r, pc_lock_r;
  lock_state_e           lock_state_r;
  logic [63:0]           instret_cnt_r;

  toy_commit_lane_sel #(
    .RETIRE_PORTS (RETIRE_PORTS),
    .IDX_W        (IDX_W),
    .CNT_W        (CNT_W)
  ) u_lane_sel (
    .retire_vld (retire_vld),
    .retire_rvc (retire_rvc),
    .young_idx  (young_idx_s),
    .young_ilen (young_ilen_s),
    .retire_cnt (retire_cnt_s)
  );

  assign commit_en_s = |retire_vld;
  assign jb_ret_s    = commit_en_s & retire_jb[young_idx_s];
  assign trap_hs_s   = trap_vld & trap_rdy;
  assign debug_hs_s  = debug_vld & trap_rdy;
  assign next_pc_s   = (jb_ret_s & jb_pc_update_en) ? jb_pc_val
                     : retire_pc[young_idx_s] + {{(ADDR_WIDTH-3){1'b0}}, young_ilen_s};
  assign trap_tgt_s  = indebug_break_en  ? ADDR_WIDTH'(DBG_LOOP_ADDR)
                     : indebug_exception ? ADDR_WIDTH'(DBG_EXP_ADDR) : csr_mtvec;

  assign sret_en     = spu_return_en & (spu_return_type == RET_SRET);
  assign mret_en     = spu_return_en & (spu_return_type == RET_MRET);
  assign dret_en     = spu_return_en & (spu_return_type == RET_DRET);
  assign ret_pulse_s = sret_en | mret_en | dret_en;

  // xRET return address; the reserved encoding falls back to mepc.
  always_comb begin
    case (ret_type_e'(spu_return_type))
      RET_SRET: ret_tgt_s = csr_sepc;
      RET_DRET: ret_tgt_s = csr_dpc;
      RET_MRET: ret_tgt_s = csr_mepc;
      default:  ret_tgt_s = csr_mepc;
    endcase
  end

  // Architectural PC update; a same-cycle commit overrides any trap/debug target.
  always_comb begin
    if (commit_en_s)        cur_pc_nxt_s = next_pc_s;
    else if (trap_hs_s)     cur_pc_nxt_s = trap_tgt_s;
    else if (debug_hs_s)    cur_pc_nxt_s = ADDR_WIDTH'(DBG_PC_ADDR);
    else if (spu_return_en) cur_pc_nxt_s = ret_tgt_s;
    else                    cur_pc_nxt_s = current_pc_r;
  end

  assign real_pc = (commit_en_s & (trap_hs_s | debug_hs_s)) ? next_pc_s : current_pc_r;

  // Redirect arbitration; a trap during single-step moves the PC without redirecting.
  always_comb begin
    rd_rel_s = 1'b1;
    rd_upd_s = 1'b1;
    rd_val_s = {ADDR_WIDTH{1'b0}};
    if (jb_ret_s) begin
      rd_rel_s = jb_pc_release_en;
      rd_upd_s = jb_pc_update_en;
      rd_val_s = jb_pc_val;
    end else if (debug_hs_s) begin
      rd_val_s = ADDR_WIDTH'(DBG_PC_ADDR);
    end else if (trap_hs_s & ~debug_step_en) begin
      rd_val_s = trap_tgt_s;
    end else if (mret_en) begin
      rd_val_s = csr_mepc;
    end else if (sret_en) begin
      rd_val_s = csr_sepc;
    end else if (dret_en) begin
      rd_val_s = csr_dpc;
    end else begin
      rd_rel_s = 1'b0;
      rd_upd_s = 1'b0;
    end
  end

  // Lock FSM next state; an issued release always wins.
  always_comb begin
    lock_nxt_s = lock_state_r;
    if (pc_release_en_r) begin
      lock_nxt_s = LOCK_UNLOCKED;
    end else begin
      case (lock_state_r)
        LOCK_UNLOCKED: begin
          if (trap_hs_s | debug_hs_s) lock_nxt_s = LOCK_ENTER;
          else if (ret_pulse_s)       lock_nxt_s = LOCK_EXIT;
          else                        lock_nxt_s = LOCK_UNLOCKED;
        end
        LOCK_ENTER: lock_nxt_s = LOCK_ENTER;
        LOCK_EXIT:  lock_nxt_s = LOCK_EXIT;
        default:    lock_nxt_s = LOCK_UNLOCKED;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_pc_r    <= RESET_PC;
      pc_release_en_r <= 1'b0;
      pc_update_en_r  <= 1'b0;
      pc_val_r        <= {ADDR_WIDTH{1'b0}};
      lock_state_r    <= LOCK_UNLOCKED;
      pc_lock_r       <= 1'b0;
      instret_cnt_r   <= 64'd0;
    end else begin
      current_pc_r    <= cur_pc_nxt_s;
      pc_release_en_r <= rd_rel_s;
      pc_update_en_r  <= rd_upd_s;
      pc_val_r        <= rd_val_s;
      lock_state_r    <= lock_nxt_s;
      pc_lock_r       <= (lock_nxt_s != LOCK_UNLOCKED);
      if (instret_inhibit) instret_cnt_r <= instret_cnt_r;
      else                 instret_cnt_r <= instret_cnt_r + {{(64-CNT_W){1'b0}}, retire_cnt_s};
    end
  end

  assign pc_release_en = pc_release_en_r;
  assign pc_update_en  = pc_update_en_r;
  assign pc_val        = pc_val_r;
  assign pc_lock       = pc_lock_r;
  assign instret_cnt   = instret_cnt_r;

`ifdef TOY_SIM
  toy_commit_chk #(.RETIRE_PORTS(RETIRE_PORTS)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .retire_vld (retire_vld),
    .retire_jb  (retire_jb)
  );
`endif

endmodule

`ifdef TOY_SIM
// Input-protocol checks: contiguous valid lanes, jump/branch only on the youngest lane.
module toy_commit_chk #(
  parameter int RETIRE_PORTS = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic [RETIRE_PORTS-1:0] retire_vld,
  input logic [RETIRE_PORTS-1:0] retire_jb
);
  logic [RETIRE_PORTS:0] vld_ext_s;
  assign vld_ext_s = {1'b0, retire_vld};

  a_vld_contig: assert property (@(posedge clk) disable iff (!rst_n)
    ((vld_ext_s + {{RETIRE_PORTS{1'b0}}, 1'b1}) & vld_ext_s) == '0);
  a_jb_young: assert property (@(posedge clk) disable iff (!rst_n)
    (retire_jb == '0) || (retire_jb == (retire_vld ^ (retire_vld >> 1))));
endmodule
`endif

// File: tb/tb_toy_commit_ctrl.sv
// Directed self-checking bench for toy_commit_ctrl with hand-computed expectations.
// Expected RVC results follow TOY_COMMIT_RVC_EN as seen by the bench.
module tb_toy_commit_ctrl;

  localparam int RP = 4;
  localparam int AW = 32;

  logic              clk, rst_n;
  logic [RP-1:0]     retire_vld, retire_rvc, retire_jb;
  logic [RP-1:0][AW-1:0] retire_pc;
  logic              jb_pc_release_en, jb_pc_update_en;
  logic [AW-1:0]     jb_pc_val;
  logic              trap_vld, debug_vld, trap_rdy;
  logic              indebug_break_en, indebug_exception, debug_step_en;
  logic [AW-1:0]     csr_mtvec, csr_mepc, csr_sepc, csr_dpc;
  logic              spu_return_en;
  logic [1:0]        spu_return_type;
  logic              instret_inhibit;
  logic [AW-1:0]     real_pc, pc_val;
  logic              pc_release_en, pc_update_en, pc_lock;
  logic              mret_en, sret_en, dret_en;
  logic [63:0]       instret_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;

  toy_commit_ctrl #(.RETIRE_PORTS(RP), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .retire_vld(retire_vld), .retire_pc(retire_pc), .retire_rvc(retire_rvc),
    .retire_jb(retire_jb), .jb_pc_release_en(jb_pc_release_en),
    .jb_pc_update_en(jb_pc_update_en), .jb_pc_val(jb_pc_val),
    .trap_vld(trap_vld), .debug_vld(debug_vld), .trap_rdy(trap_rdy),
    .indebug_break_en(indebug_break_en), .indebug_exception(indebug_exception),
    .debug_step_en(debug_step_en), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_sepc(csr_sepc), .csr_dpc(csr_dpc), .spu_return_en(spu_return_en),
    .spu_return_type(spu_return_type), .instret_inhibit(instret_inhibit),
    .real_pc(real_pc), .pc_release_en(pc_release_en), .pc_update_en(pc_update_en),
    .pc_val(pc_val), .pc_lock(pc_lock), .mret_en(mret_en), .sret_en(sret_en),
    .dret_en(dret_en), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    retire_vld = 4'b0000; retire_rvc = 4'b0000; retire_jb = 4'b0000;
    retire_pc = '0;
    jb_pc_release_en = 1'b0; jb_pc_update_en = 1'b0; jb_pc_val = 32'h0;
    trap_vld = 1'b0; debug_vld = 1'b0; trap_rdy = 1'b0;
    indebug_break_en = 1'b0; indebug_exception = 1'b0; debug_step_en = 1'b0;
    csr_mtvec = 32'h0; csr_mepc = 32'h400; csr_sepc = 32'h500; csr_dpc = 32'h600;
    spu_return_en = 1'b0; spu_return_type = 2'b00; instret_inhibit = 1'b0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    begin_cycle();
    end_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check_val("rst_real_pc", 64'(real_pc), 64'h0);
    check_val("rst_lock", 64'(pc_lock), 64'h0);
    check_val("rst_release", 64'(pc_release_en), 64'h0);
    check_val("rst_update", 64'(pc_update_en), 64'h0);
    check_val("rst_pc_val", 64'(pc_val), 64'h0);
    check_val("rst_instret", instret_cnt, 64'd0);
    rst_n = 1'b1;

    // Three-lane commit, no jump/branch
    begin_cycle();
    retire_vld = 4'b0111;
    retire_pc[0] = 32'h100; retire_pc[1] = 32'h104; retire_pc[2] = 32'h108;
    end_cycle();
    check_val("c3_real_pc", 64'(real_pc), 64'h10C);
    check_val("c3_instret", instret_cnt, 64'd3);
    check_val("c3_update", 64'(pc_update_en), 64'h0);

    // Jump/branch on youngest lane 1
    begin_cycle();
    retire_vld = 4'b0011; retire_jb = 4'b0010;
    retire_pc[0] = 32'h200; retire_pc[1] = 32'h204;
    jb_pc_release_en = 1'b1; jb_pc_update_en = 1'b1; jb_pc_val = 32'h2000;
    end_cycle();
    check_val("jb_real_pc", 64'(real_pc), 64'h2000);
    check_val("jb_update", 64'(pc_update_en), 64'h1);
    check_val("jb_release", 64'(pc_release_en), 64'h1);
    check_val("jb_pc_val", 64'(pc_val), 64'h2000);
    check_val("jb_instret", instret_cnt, 64'd5);

    // Trap in the same cycle as an issued release: FSM must stay unlocked
    begin_cycle();
    trap_vld = 1'b1; trap_rdy = 1'b1; csr_mtvec = 32'h80;
    #1 check_val("rt_comb_real_pc", 64'(real_pc), 64'h2000);
    end_cycle();
    check_val("rt_pc_val", 64'(pc_val), 64'h80);
    check_val("rt_real_pc", 64'(real_pc), 64'h80);
    check_val("rt_lock", 64'(pc_lock), 64'h0);
    idle_cycle();
    check_val("idle_update", 64'(pc_update_en), 64'h0);
    check_val("idle_pc_val", 64'(pc_val), 64'h0);

    // Plain trap: lock until the redirect release is issued
    begin_cycle();
    trap_vld = 1'b1; trap_rdy = 1'b1; csr_mtvec = 32'h90;
    end_cycle();
    check_val("tr_pc_val", 64'(pc_val), 64'h90);
    check_val("tr_update", 64'(pc_update_en), 64'h1);
    check_val("tr_lock", 64'(pc_lock), 64'h1);
    idle_cycle();
    check_val("tr_unlock", 64'(pc_lock), 64'h0);
    idle_cycle();

    // Trap in step mode: PC moves, no redirect, lock held
    begin_cycle();
    trap_vld = 1'b1; trap_rdy = 1'b1; csr_mtvec = 32'h180; debug_step_en = 1'b1;
    end_cycle();
    check_val("st_real_pc", 64'(real_pc), 64'h180);
    check_val("st_update", 64'(pc_update_en), 64'h0);
    check_val("st_release", 64'(pc_release_en), 64'h0);
    check_val("st_lock", 64'(pc_lock), 64'h1);
    idle_cycle();
    check_val("st_lock_held", 64'(pc_lock), 64'h1);

    // Jump/branch release on lane 0 clears the lock
    begin_cycle();
    retire_vld = 4'b0001; retire_jb = 4'b0001; retire_pc[0] = 32'h184;
    jb_pc_release_en = 1'b1; jb_pc_update_en = 1'b1; jb_pc_val = 32'h300;
    end_cycle();
    check_val("jb0_real_pc", 64'(real_pc), 64'h300);
    check_val("jb0_release", 64'(pc_release_en), 64'h1);
    check_val("jb0_instret", instret_cnt, 64'd6);
    idle_cycle();
    check_val("jb0_unlock", 64'(pc_lock), 64'h0);
    idle_cycle();

    // MRET
    begin_cycle();
    spu_return_en = 1'b1; spu_return_type = 2'b01;
    #1 check_val("mret_pulses", 64'({mret_en, sret_en, dret_en}), 64'b100);
    end_cycle();
    check_val("mret_pc_val", 64'(pc_val), 64'h400);
    check_val("mret_real_pc", 64'(real_pc), 64'h400);
    check_val("mret_lock", 64'(pc_lock), 64'h1);
    idle_cycle();
    check_val("mret_unlock", 64'(pc_lock), 64'h0);
    idle_cycle();

    // Trap and commit together: PC takes the commit, redirect carries the trap
    begin_cycle();
    retire_vld = 4'b0001; retire_pc[0] = 32'h700;
    trap_vld = 1'b1; trap_rdy = 1'b1; csr_mtvec = 32'h80;
    #1 check_val("tc_comb_real_pc", 64'(real_pc), 64'h704);
    end_cycle();
    check_val("tc_real_pc", 64'(real_pc), 64'h704);
    check_val("tc_pc_val", 64'(pc_val), 64'h80);
    check_val("tc_lock", 64'(pc_lock), 64'h1);
    check_val("tc_instret", instret_cnt, 64'd7);
    idle_cycle();
    idle_cycle();

    // Debug entry
    begin_cycle();
    debug_vld = 1'b1; trap_rdy = 1'b1;
    end_cycle();
    check_val("dbg_pc_val", 64'(pc_val), 64'h800);
    check_val("dbg_real_pc", 64'(real_pc), 64'h800);
    check_val("dbg_lock", 64'(pc_lock), 64'h1);
    idle_cycle();
    idle_cycle();

    // Compressed instruction on lane 0
    begin_cycle();
    retire_vld = 4'b0001; retire_rvc = 4'b0001; retire_pc[0] = 32'h100;
    end_cycle();
`ifdef TOY_COMMIT_RVC_EN
    check_val("rvc_real_pc", 64'(real_pc), 64'h102);
`else
    check_val("rvc_real_pc", 64'(real_pc), 64'h104);
`endif
    check_val("rvc_instret", instret_cnt, 64'd8);

    // Four lanes with the counter inhibited
    begin_cycle();
    retire_vld = 4'b1111; instret_inhibit = 1'b1;
    retire_pc[0] = 32'h104; retire_pc[1] = 32'h108;
    retire_pc[2] = 32'h10C; retire_pc[3] = 32'h110;
    end_cycle();
    check_val("inh_real_pc", 64'(real_pc), 64'h114);
    check_val("inh_instret", instret_cnt, 64'd8);

    // DRET
    begin_cycle();
    spu_return_en = 1'b1; spu_return_type = 2'b10;
    #1 check_val("dret_pulses", 64'({mret_en, sret_en, dret_en}), 64'b001);
    end_cycle();
    check_val("dret_pc_val", 64'(pc_val), 64'h600);
    idle_cycle();
    idle_cycle();

    // Reserved return type: mepc, no pulse, no redirect
    begin_cycle();
    spu_return_en = 1'b1; spu_return_type = 2'b11;
    #1 check_val("rsv_pulses", 64'({mret_en, sret_en, dret_en}), 64'b000);
    end_cycle();
    check_val("rsv_real_pc", 64'(real_pc), 64'h400);
    check_val("rsv_update", 64'(pc_update_en), 64'h0);
    check_val("rsv_lock", 64'(pc_lock), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
